// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX outputs, runs one data-memory
// transaction over a req/ack port, and hands the result on to WB.
module mem_stage #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int TIMEOUT     = 255,
  parameter int DEST_SRC_W  = 2,
  parameter int REG_IDX_W   = 5,
  parameter int MEM_COUNT_W = 2,
  parameter logic [DEST_SRC_W-1:0] DEST_SRC_NONE = '0,
  parameter logic [DEST_SRC_W-1:0] DEST_SRC_MEM  = DEST_SRC_W'(2)
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   stall,
  input  logic [ADDR_W-1:0]      i_pc,
  input  logic [31:0]            i_instr,
  input  logic [DEST_SRC_W-1:0]  i_dest_src,
  input  logic [REG_IDX_W-1:0]   i_dest_reg,
  input  logic [WORD_W-1:0]      i_alu_eval,
  input  logic [ADDR_W-1:0]      i_mem_req_addr,
  input  logic [WORD_W-1:0]      i_mem_req_wr_data,
  input  logic                   i_mem_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
  output logic                   o_dmem_req,
  output logic [ADDR_W-1:0]      o_dmem_addr,
  output logic                   o_dmem_wr_en,
  output logic [3:0]             o_dmem_byte_en,
  output logic [WORD_W-1:0]      o_dmem_wr_data,
  input  logic                   i_dmem_ack,
  input  logic [WORD_W-1:0]      i_dmem_rd_data,
  output logic                   o_stall,
  output logic [ADDR_W-1:0]      o_pc,
  output logic [31:0]            o_instr,
  output logic [DEST_SRC_W-1:0]  o_dest_src,
  output logic [REG_IDX_W-1:0]   o_dest_reg,
  output logic [WORD_W-1:0]      o_dest_data,
  output logic                   o_misalign,
  output logic                   o_timeout
);

  localparam int LANE_W  = WORD_W / 4;
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  localparam logic [MEM_COUNT_W-1:0] CNT_NONE = MEM_COUNT_W'(0);
  localparam logic [MEM_COUNT_W-1:0] CNT_BYTE = MEM_COUNT_W'(1);
  localparam logic [MEM_COUNT_W-1:0] CNT_HALF = MEM_COUNT_W'(2);
  localparam logic [MEM_COUNT_W-1:0] CNT_WORD = MEM_COUNT_W'(3);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]      pc_reg;
  logic [31:0]            instr_reg;
  logic [DEST_SRC_W-1:0]  dest_src_reg;
  logic [REG_IDX_W-1:0]   dest_reg_reg;
  logic [WORD_W-1:0]      alu_eval_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic [WORD_W-1:0]      wr_data_reg;
  logic                   wr_en_reg;
  logic [MEM_COUNT_W-1:0] count_reg;
  logic [WORD_W-1:0]      load_data_reg;
  logic [TIMER_W-1:0]     timer_reg;
  logic                   timeout_reg;

  logic                   busy;
  logic                   capture;
  logic                   timer_expired;
  logic [WORD_W-1:0]      load_ext;
  logic [WORD_W-1:0]      wr_data_placed;
  logic [3:0]             byte_en;
  logic [LANE_W-1:0]      rd_lane [4];
  logic [LANE_W-1:0]      byte_sel;
  logic [2*LANE_W-1:0]    half_sel;

  function automatic logic is_misaligned(input logic [MEM_COUNT_W-1:0] cnt,
                                         input logic [1:0] lo);
    case (cnt)
      CNT_HALF: is_misaligned = lo[0];
      CNT_WORD: is_misaligned = (lo != 2'b00);
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

  assign busy          = (state_reg == ST_BUSY);
  assign capture       = !stall && !busy;
  assign timer_expired = (timer_reg == TIMER_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_reg       <= '0;
      instr_reg    <= '0;
      dest_src_reg <= DEST_SRC_NONE;
      dest_reg_reg <= '0;
      alu_eval_reg <= '0;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      wr_en_reg    <= 1'b0;
      count_reg    <= CNT_NONE;
    end else if (capture) begin
      pc_reg       <= i_pc;
      instr_reg    <= i_instr;
      dest_src_reg <= i_dest_src;
      dest_reg_reg <= i_dest_reg;
      alu_eval_reg <= i_alu_eval;
      addr_reg     <= i_mem_req_addr;
      wr_data_reg  <= i_mem_req_wr_data;
      wr_en_reg    <= i_mem_req_wr_en;
      count_reg    <= i_mem_req_count;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The incoming entry decides the next state so a memory op starts requesting
  // in the very cycle it becomes visible in the stage register.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BUSY: begin
        if (i_dmem_ack || timer_expired) state_next = ST_DONE;
      end
      default: begin
        if (capture) begin
          if ((i_mem_req_count != CNT_NONE) &&
              !is_misaligned(i_mem_req_count, i_mem_req_addr[1:0]))
            state_next = ST_BUSY;
          else
            state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      timer_reg     <= '0;
      timeout_reg   <= 1'b0;
      load_data_reg <= '0;
    end else begin
      timer_reg <= busy ? timer_reg + 1'b1 : '0;
      if (capture) begin
        timeout_reg   <= 1'b0;
        load_data_reg <= '0;
      end else if (busy && i_dmem_ack) begin
        load_data_reg <= load_ext;
      end else if (busy && timer_expired) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = i_dmem_rd_data[gi*LANE_W +: LANE_W];
      assign byte_en[gi] = ((count_reg == CNT_BYTE) && (addr_reg[1:0] == 2'(gi))) ||
                           ((count_reg == CNT_HALF) && (addr_reg[1] == 1'(gi / 2))) ||
                           (count_reg == CNT_WORD);
      assign wr_data_placed[gi*LANE_W +: LANE_W] =
          (count_reg == CNT_BYTE) ? wr_data_reg[LANE_W-1:0] :
          (count_reg == CNT_HALF) ? wr_data_reg[(gi%2)*LANE_W +: LANE_W] :
                                    wr_data_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign byte_sel = rd_lane[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};

  // instr[14] distinguishes the unsigned loads (LBU/LHU) from LB/LH.
  always_comb begin
    load_ext = i_dmem_rd_data;
    case (count_reg)
      CNT_BYTE: load_ext = instr_reg[14] ? WORD_W'(byte_sel)
                         : {{(WORD_W-LANE_W){byte_sel[LANE_W-1]}}, byte_sel};
      CNT_HALF: load_ext = instr_reg[14] ? WORD_W'(half_sel)
                         : {{(WORD_W-2*LANE_W){half_sel[2*LANE_W-1]}}, half_sel};
      default:  load_ext = i_dmem_rd_data;
    endcase
  end

  assign o_dmem_req     = busy;
  assign o_dmem_addr    = {addr_reg[ADDR_W-1:2], 2'b00};
  assign o_dmem_wr_en   = busy & wr_en_reg;
  assign o_dmem_byte_en = busy ? byte_en : 4'b0000;
  assign o_dmem_wr_data = wr_data_placed;
  assign o_stall        = busy;

  assign o_pc        = pc_reg;
  assign o_instr     = instr_reg;
  assign o_dest_reg  = dest_reg_reg;
  assign o_misalign  = is_misaligned(count_reg, addr_reg[1:0]);
  assign o_timeout   = timeout_reg;
  assign o_dest_src  = (o_misalign || timeout_reg) ? DEST_SRC_NONE : dest_src_reg;
  assign o_dest_data = (dest_src_reg == DEST_SRC_MEM) ? load_data_reg : alu_eval_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single transactions plus
// hand-written timeout, reset and back-to-back sequences.
module tb_mem_stage;

  localparam logic [1:0] DS_NONE = 2'd0, DS_ALU = 2'd1, DS_MEM = 2'd2;
  localparam logic [1:0] C_NONE = 2'd0, C_BYTE = 2'd1, C_HALF = 2'd2, C_WORD = 2'd3;
  localparam int NV = 14;

  logic        clk, clr_n, stall;
  logic [31:0] i_pc, i_instr, i_alu_eval, i_mem_req_addr, i_mem_req_wr_data;
  logic [1:0]  i_dest_src, i_mem_req_count;
  logic [4:0]  i_dest_reg;
  logic        i_mem_req_wr_en;
  logic        o_dmem_req, o_dmem_wr_en, i_dmem_ack, o_stall, o_misalign, o_timeout;
  logic [31:0] o_dmem_addr, o_dmem_wr_data, i_dmem_rd_data, o_pc, o_instr, o_dest_data;
  logic [3:0]  o_dmem_byte_en;
  logic [1:0]  o_dest_src;
  logic [4:0]  o_dest_reg;

  mem_stage #(.TIMEOUT(8)) dut (
    .clk(clk), .clr_n(clr_n), .stall(stall),
    .i_pc(i_pc), .i_instr(i_instr), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
    .i_alu_eval(i_alu_eval), .i_mem_req_addr(i_mem_req_addr),
    .i_mem_req_wr_data(i_mem_req_wr_data), .i_mem_req_wr_en(i_mem_req_wr_en),
    .i_mem_req_count(i_mem_req_count),
    .o_dmem_req(o_dmem_req), .o_dmem_addr(o_dmem_addr), .o_dmem_wr_en(o_dmem_wr_en),
    .o_dmem_byte_en(o_dmem_byte_en), .o_dmem_wr_data(o_dmem_wr_data),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rd_data(i_dmem_rd_data),
    .o_stall(o_stall), .o_pc(o_pc), .o_instr(o_instr), .o_dest_src(o_dest_src),
    .o_dest_reg(o_dest_reg), .o_dest_data(o_dest_data),
    .o_misalign(o_misalign), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cyc = 0;
  int acked = 0;

  always @(posedge clk) begin
    if (o_dmem_req) req_cyc <= req_cyc + 1;
    if (o_dmem_req && i_dmem_ack) acked <= acked + 1;
  end

  typedef struct {
    logic [1:0]  count;
    logic        wr_en;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  dsrc;
    logic [31:0] alu;
    int          ack_dly;
    logic        exp_req;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic [1:0]  exp_dsrc;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] dsrc,
                       input logic [4:0] dreg, input logic [31:0] alu, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic wr_en, input logic [1:0] count);
    i_pc = pc; i_instr = instr; i_dest_src = dsrc; i_dest_reg = dreg; i_alu_eval = alu;
    i_mem_req_addr = addr; i_mem_req_wr_data = wdata; i_mem_req_wr_en = wr_en;
    i_mem_req_count = count;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int busy_cyc;
    logic [31:0] pc;
    pc = 32'h1000 + 32'(idx * 4);
    drive(pc, v.instr, v.dsrc, 5'(idx + 1), v.alu, v.addr, v.wdata, v.wr_en, v.count);
    step();
    check("pc", o_pc, pc);
    check("dest_reg", 32'(o_dest_reg), 32'(idx + 1));
    if (v.exp_req) begin
      check("req_addr", o_dmem_addr, {v.addr[31:2], 2'b00});
      check("req_wr_en", 32'(o_dmem_wr_en), 32'(v.wr_en));
      if (v.wr_en) begin
        check("byte_en", 32'(o_dmem_byte_en), 32'(v.exp_be));
        check("wr_data", o_dmem_wr_data, v.exp_wdata);
      end
      busy_cyc = (o_dmem_req && o_stall) ? 1 : 0;
      for (int c = 1; c < v.ack_dly; c++) begin
        step();
        if (o_dmem_req && o_stall) busy_cyc++;
      end
      i_dmem_ack = 1'b1;
      i_dmem_rd_data = v.rdata;
      step();
      i_dmem_ack = 1'b0;
      i_dmem_rd_data = 32'h5A5A5A5A;
      check("busy_cycles", 32'(busy_cyc), 32'(v.ack_dly));
    end
    check("req_after", 32'(o_dmem_req), 32'h0);
    check("stall_after", 32'(o_stall), 32'h0);
    check("misalign", 32'(o_misalign), 32'(v.exp_mis));
    check("timeout", 32'(o_timeout), 32'h0);
    check("dest_src", 32'(o_dest_src), 32'(v.exp_dsrc));
    if (!v.exp_mis) check("dest_data", o_dest_data, v.exp_data);
    $display("txn %0d addr=%h count=%0d dest_data=%h misalign=%0b", idx, v.addr, v.count,
             o_dest_data, o_misalign);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int busy_cyc;
    //             count  we    instr         addr          wdata         rdata         dsrc    alu           dly  req   exp_data      be       exp_wdata     mis   exp_dsrc
    vecs[0]  = '{C_NONE, 1'b0, 32'h00000033, 32'h11112222, 32'h0,        32'h0,        DS_ALU,  32'h11112222, 0, 1'b0, 32'h11112222, 4'b0000, 32'h0,        1'b0, DS_ALU};
    vecs[1]  = '{C_WORD, 1'b0, 32'h00002003, 32'h00000100, 32'h0,        32'hDEADBEEF, DS_MEM,  32'h00000100, 3, 1'b1, 32'hDEADBEEF, 4'b0000, 32'h0,        1'b0, DS_MEM};
    vecs[2]  = '{C_BYTE, 1'b0, 32'h00000003, 32'h00000103, 32'h0,        32'h80FFFFFF, DS_MEM,  32'h00000103, 2, 1'b1, 32'hFFFFFF80, 4'b0000, 32'h0,        1'b0, DS_MEM};
    vecs[3]  = '{C_BYTE, 1'b0, 32'h00004003, 32'h00000103, 32'h0,        32'h80FFFFFF, DS_MEM,  32'h00000103, 1, 1'b1, 32'h00000080, 4'b0000, 32'h0,        1'b0, DS_MEM};
    vecs[4]  = '{C_HALF, 1'b1, 32'h00001023, 32'h00000102, 32'h1234ABCD, 32'h0,        DS_NONE, 32'h00000102, 1, 1'b1, 32'h00000102, 4'b1100, 32'hABCDABCD, 1'b0, DS_NONE};
    vecs[5]  = '{C_WORD, 1'b0, 32'h00002003, 32'h00000101, 32'h0,        32'h0,        DS_MEM,  32'h00000101, 0, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, DS_NONE};
    vecs[6]  = '{C_HALF, 1'b0, 32'h00001003, 32'h00000102, 32'h0,        32'h80011234, DS_MEM,  32'h00000102, 2, 1'b1, 32'hFFFF8001, 4'b0000, 32'h0,        1'b0, DS_MEM};
    vecs[7]  = '{C_HALF, 1'b0, 32'h00005003, 32'h00000100, 32'h0,        32'h8001F234, DS_MEM,  32'h00000100, 1, 1'b1, 32'h0000F234, 4'b0000, 32'h0,        1'b0, DS_MEM};
    vecs[8]  = '{C_BYTE, 1'b1, 32'h00000023, 32'h00000101, 32'h000000A5, 32'h0,        DS_NONE, 32'h00000101, 2, 1'b1, 32'h00000101, 4'b0010, 32'hA5A5A5A5, 1'b0, DS_NONE};
    vecs[9]  = '{C_WORD, 1'b1, 32'h00002023, 32'h00000104, 32'hCAFEF00D, 32'h0,        DS_NONE, 32'h00000104, 1, 1'b1, 32'h00000104, 4'b1111, 32'hCAFEF00D, 1'b0, DS_NONE};
    vecs[10] = '{C_HALF, 1'b0, 32'h00001003, 32'h00000101, 32'h0,        32'h0,        DS_MEM,  32'h00000101, 0, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, DS_NONE};
    vecs[11] = '{C_BYTE, 1'b0, 32'h00000003, 32'h00000101, 32'h0,        32'h00007F00, DS_MEM,  32'h00000101, 1, 1'b1, 32'h0000007F, 4'b0000, 32'h0,        1'b0, DS_MEM};
    vecs[12] = '{C_BYTE, 1'b1, 32'h00000023, 32'h00000103, 32'h12345678, 32'h0,        DS_NONE, 32'h00000103, 1, 1'b1, 32'h00000103, 4'b1000, 32'h78787878, 1'b0, DS_NONE};
    vecs[13] = '{C_WORD, 1'b1, 32'h00002023, 32'h00000102, 32'h00000011, 32'h0,        DS_NONE, 32'h00000102, 0, 1'b0, 32'h00000102, 4'b0000, 32'h0,        1'b1, DS_NONE};

    // Reset: live inputs must not leak into the stage while clr_n is low.
    clr_n = 1'b0; stall = 1'b0; i_dmem_ack = 1'b0; i_dmem_rd_data = 32'h0;
    drive(32'h0000ABCD, 32'h00002003, DS_MEM, 5'd7, 32'h100, 32'h100, 32'h55, 1'b1, C_WORD);
    step(); step();
    check("rst_req", 32'(o_dmem_req), 0);
    check("rst_stall", 32'(o_stall), 0);
    check("rst_addr", o_dmem_addr, 0);
    check("rst_wr_en", 32'(o_dmem_wr_en), 0);
    check("rst_byte_en", 32'(o_dmem_byte_en), 0);
    check("rst_wr_data", o_dmem_wr_data, 0);
    check("rst_pc", o_pc, 0);
    check("rst_instr", o_instr, 0);
    check("rst_dest_src", 32'(o_dest_src), 0);
    check("rst_dest_reg", 32'(o_dest_reg), 0);
    check("rst_dest_data", o_dest_data, 0);
    check("rst_misalign", 32'(o_misalign), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    drive(0, 0, DS_NONE, 0, 0, 0, 0, 1'b0, C_NONE);
    clr_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) apply_vec(vecs[i], i);

    // Timeout: no ack ever, request must last exactly TIMEOUT cycles.
    drive(32'h2000, 32'h00002003, DS_MEM, 5'd9, 32'h200, 32'h200, 0, 1'b0, C_WORD);
    step();
    busy_cyc = 0;
    for (int c = 0; c < 20 && o_dmem_req; c++) begin
      busy_cyc++;
      step();
    end
    check("to_req_cycles", 32'(busy_cyc), 8);
    check("to_timeout", 32'(o_timeout), 1);
    check("to_dest_src", 32'(o_dest_src), 32'(DS_NONE));
    check("to_stall", 32'(o_stall), 0);
    $display("txn timeout req_cycles=%0d timeout=%0b", busy_cyc, o_timeout);
    stall = 1'b1;
    drive(32'h3000, 32'h00000033, DS_ALU, 5'd10, 32'h33, 0, 0, 1'b0, C_NONE);
    step(); step();
    check("to_hold_flag", 32'(o_timeout), 1);
    check("to_hold_pc", o_pc, 32'h2000);
    stall = 1'b0;
    step();
    check("to_clear_flag", 32'(o_timeout), 0);
    check("to_next_pc", o_pc, 32'h3000);
    check("to_next_data", o_dest_data, 32'h33);

    // Ack in the final timer cycle beats the timeout.
    drive(32'h4000, 32'h00002003, DS_MEM, 5'd11, 32'h300, 32'h300, 0, 1'b0, C_WORD);
    step();
    for (int c = 1; c < 8; c++) step();
    check("late_req", 32'(o_dmem_req), 1);
    i_dmem_ack = 1'b1; i_dmem_rd_data = 32'h01234567;
    step();
    check("late_timeout", 32'(o_timeout), 0);
    check("late_data", o_dest_data, 32'h01234567);
    check("late_dest_src", 32'(o_dest_src), 32'(DS_MEM));
    $display("txn late_ack dest_data=%h timeout=%0b", o_dest_data, o_timeout);
    // A stray ack in DONE must not overwrite the latched load.
    stall = 1'b1; i_dmem_rd_data = 32'hFFFFFFFF;
    step();
    i_dmem_ack = 1'b0;
    check("stray_ack_data", o_dest_data, 32'h01234567);
    check("stray_ack_req", 32'(o_dmem_req), 0);
    stall = 1'b0;

    // Reset in the middle of BUSY drops the request at once.
    drive(32'h5000, 32'h00002003, DS_MEM, 5'd12, 32'h400, 32'h400, 0, 1'b0, C_WORD);
    step(); step();
    check("mid_req_before", 32'(o_dmem_req), 1);
    #2 clr_n = 1'b0;
    #1;
    check("mid_req_drop", 32'(o_dmem_req), 0);
    check("mid_stall_drop", 32'(o_stall), 0);
    check("mid_pc_clear", o_pc, 0);
    drive(0, 0, DS_NONE, 0, 0, 0, 0, 1'b0, C_NONE);
    step();
    clr_n = 1'b1;
    n0 = req_cyc;
    step(); step(); step();
    check("mid_no_resume", 32'(req_cyc - n0), 0);
    $display("txn reset_mid_busy req=%0b", o_dmem_req);

    // ALU -> SW -> ALU with stall pulses: one store, no loss or duplication.
    n0 = req_cyc;
    busy_cyc = acked;
    drive(32'h6000, 32'h00000033, DS_ALU, 5'd3, 32'hA1, 0, 0, 1'b0, C_NONE);
    step();
    check("b2b_alu1_data", o_dest_data, 32'hA1);
    check("b2b_alu1_stall", 32'(o_stall), 0);
    drive(32'h6004, 32'h00002023, DS_NONE, 5'd0, 32'h500, 32'h500, 32'hCAFEBABE, 1'b1, C_WORD);
    stall = 1'b1;
    step();
    check("b2b_stall_hold_pc", o_pc, 32'h6000);
    check("b2b_stall_no_req", 32'(o_dmem_req), 0);
    stall = 1'b0;
    step();
    check("b2b_sw_req", 32'(o_dmem_req), 1);
    check("b2b_sw_pc", o_pc, 32'h6004);
    check("b2b_sw_be", 32'(o_dmem_byte_en), 32'hF);
    check("b2b_sw_data", o_dmem_wr_data, 32'hCAFEBABE);
    i_dmem_ack = 1'b1;
    step();
    i_dmem_ack = 1'b0;
    drive(32'h6008, 32'h00000033, DS_ALU, 5'd4, 32'hA2, 0, 0, 1'b0, C_NONE);
    stall = 1'b1;
    step();
    check("b2b_done_hold_pc", o_pc, 32'h6004);
    check("b2b_done_no_req", 32'(o_dmem_req), 0);
    stall = 1'b0;
    step();
    check("b2b_alu2_pc", o_pc, 32'h6008);
    check("b2b_alu2_data", o_dest_data, 32'hA2);
    check("b2b_alu2_dest_src", 32'(o_dest_src), 32'(DS_ALU));
    check("b2b_req_cycles", 32'(req_cyc - n0), 1);
    check("b2b_acks", 32'(acked - busy_cyc), 1);
    $display("txn back_to_back req_cycles=%0d", req_cyc - n0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
